// File: rtl/object_ram_server.sv
// Four-port read / one-port write object store with an INIT zeroing sweep.
// Optional macro OBJ_STORE_FWD_EN selects write-first forwarding on same-edge same-index access.
module object_ram_server #(
    parameter int OBJ_WIDTH = 103,
    parameter int DEPTH     = 128
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [3:0]                load_signal_in,
    input  logic [3:0][9:0]           load_object_index_in,
    output logic [3:0][OBJ_WIDTH-1:0] load_object_data_out,
    output logic [3:0]                load_valid_out,
    input  logic                      save_signal_in,
    input  logic [9:0]                save_object_index_in,
    input  logic [OBJ_WIDTH-1:0]      save_object_data_in,
    output logic                      ready_out,
    output logic                      range_err_out
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] DEPTH_L   = 11'(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t      state, state_nxt;
    logic [AW:0] sweep, sweep_nxt;
    logic        sweep_we;
    logic        ready;

    logic [OBJ_WIDTH-1:0] mem [DEPTH];

    logic [3:0]                rd_req;
    logic [3:0]                rd_in_range;
    logic [3:0][OBJ_WIDTH-1:0] rd_data;
    logic                      wr_req;
    logic                      wr_in_range;
    logic                      wr_ok;
    logic                      err_hit;

    logic [3:0]                v1, v2;
    logic [3:0][OBJ_WIDTH-1:0] d1, d2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= INIT;
            sweep <= '0;
        end else begin
            state <= state_nxt;
            sweep <= sweep_nxt;
        end
    end

    // The sweep counter runs one past the last slot so READY arrives the cycle after the final clear.
    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        sweep_we  = 1'b0;
        case (state)
            INIT: begin
                if (sweep == DEPTH_CNT) begin
                    state_nxt = READY;
                end else begin
                    sweep_we  = 1'b1;
                    sweep_nxt = sweep + 1'b1;
                end
            end
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    assign ready     = (state == READY);
    assign ready_out = ready;

    assign rd_req      = load_signal_in & {4{ready}};
    assign wr_req      = save_signal_in & ready;
    assign wr_in_range = ({1'b0, save_object_index_in} < DEPTH_L);
    assign wr_ok       = wr_req & wr_in_range;
    assign err_hit     = (|(rd_req & ~rd_in_range)) | (wr_req & ~wr_in_range);

    always_comb begin
        rd_in_range = '0;
        rd_data     = '0;
        for (int k = 0; k < 4; k++) begin
            rd_in_range[k] = ({1'b0, load_object_index_in[k]} < DEPTH_L);
            if (rd_in_range[k]) begin
                rd_data[k] = mem[load_object_index_in[k][AW-1:0]];
            end
`ifdef OBJ_STORE_FWD_EN
            if (wr_ok && rd_in_range[k] && (load_object_index_in[k] == save_object_index_in)) begin
                rd_data[k] = save_object_data_in;
            end
`endif
        end
    end

    // Storage itself is never reset; the INIT sweep clears it.
    always_ff @(posedge sys_clk) begin
        if (sweep_we) begin
            mem[sweep[AW-1:0]] <= '0;
        end else if (wr_ok) begin
            mem[save_object_index_in[AW-1:0]] <= save_object_data_in;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v1                   <= '0;
            v2                   <= '0;
            d1                   <= '0;
            d2                   <= '0;
            load_valid_out       <= '0;
            load_object_data_out <= '0;
            range_err_out        <= 1'b0;
        end else begin
            v1             <= rd_req;
            d1             <= rd_data;
            v2             <= v1;
            d2             <= d1;
            load_valid_out <= v2;
            for (int k = 0; k < 4; k++) begin
                if (v2[k]) begin
                    load_object_data_out[k] <= d2[k];
                end
            end
            if (err_hit) begin
                range_err_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_object_ram_server.sv
// Randomised bench for object_ram_server against an event-level model of the store.
// Honours OBJ_STORE_FWD_EN the same way the design does.
module tb_object_ram_server;

    localparam int W     = 103;
    localparam int DEPTH = 128;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b1;
    logic [3:0]          load_signal_in;
    logic [3:0][9:0]     load_object_index_in;
    logic [3:0][W-1:0]   load_object_data_out;
    logic [3:0]          load_valid_out;
    logic                save_signal_in;
    logic [9:0]          save_object_index_in;
    logic [W-1:0]        save_object_data_in;
    logic                ready_out;
    logic                range_err_out;

    always #5 sys_clk = ~sys_clk;

    object_ram_server #(.OBJ_WIDTH(W), .DEPTH(DEPTH)) dut (
        .sys_clk              (sys_clk),
        .sys_rst_n            (sys_rst_n),
        .load_signal_in       (load_signal_in),
        .load_object_index_in (load_object_index_in),
        .load_object_data_out (load_object_data_out),
        .load_valid_out       (load_valid_out),
        .save_signal_in       (save_signal_in),
        .save_object_index_in (save_object_index_in),
        .save_object_data_in  (save_object_data_in),
        .ready_out            (ready_out),
        .range_err_out        (range_err_out)
    );

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: memory reads zero after reset, ready after DEPTH+1 edges, reads land 2 edges later.
    logic [W-1:0] m_mem [DEPTH];
    logic [3:0]   ring_v [4];
    logic [W-1:0] ring_d [4][4];
    logic [3:0]   m_v;
    logic [W-1:0] m_d [4];
    int           m_n;
    bit           m_err;
    int           m_ec;

    always @(posedge sys_clk) begin : model_proc
        int   idx;
        int   cur;
        int   nxt;
        bit   acc;
        logic [W-1:0] rd;
        if (!sys_rst_n) begin
            m_n   = 0;
            m_err = 1'b0;
            m_ec  = 0;
            m_v   = '0;
            for (int k = 0; k < 4; k++) begin
                m_d[k]    = '0;
                ring_v[k] = '0;
            end
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            acc = (m_n >= DEPTH + 1);
            cur = m_ec % 4;
            nxt = (m_ec + 2) % 4;
            m_v = ring_v[cur];
            for (int k = 0; k < 4; k++) begin
                if (ring_v[cur][k]) m_d[k] = ring_d[cur][k];
            end
            ring_v[cur] = '0;
            if (acc) begin
                for (int k = 0; k < 4; k++) begin
                    if (load_signal_in[k]) begin
                        idx = int'(load_object_index_in[k]);
                        rd  = (idx < DEPTH) ? m_mem[idx] : '0;
`ifdef OBJ_STORE_FWD_EN
                        if (save_signal_in && idx < DEPTH && idx == int'(save_object_index_in))
                            rd = save_object_data_in;
`endif
                        if (idx >= DEPTH) m_err = 1'b1;
                        ring_v[nxt][k] = 1'b1;
                        ring_d[nxt][k] = rd;
                    end
                end
                if (save_signal_in) begin
                    idx = int'(save_object_index_in);
                    if (idx < DEPTH) m_mem[idx] = save_object_data_in;
                    else m_err = 1'b1;
                end
            end
            m_n++;
            m_ec++;
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            if (!sys_rst_n) begin
                check("rst_ready", ready_out, 0);
                check("rst_valid", load_valid_out, 0);
                check("rst_err", range_err_out, 0);
                check("rst_data_zero", load_object_data_out == '0, 1);
            end else begin
                check("ready", ready_out, m_n >= DEPTH + 1);
                check("range_err", range_err_out, m_err);
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("valid%0d", k), load_valid_out[k], m_v[k]);
                    check($sformatf("data%0d", k), load_object_data_out[k], m_d[k]);
                end
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        load_signal_in       = '0;
        load_object_index_in = '0;
        save_signal_in       = 1'b0;
        save_object_index_in = '0;
        save_object_data_in  = '0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!ready_out && cnt < 2000);
    endtask

    task automatic do_write(input int idx, input logic [W-1:0] data);
        save_signal_in       = 1'b1;
        save_object_index_in = 10'(idx);
        save_object_data_in  = data;
        step();
        idle();
    endtask

    function automatic int pick_idx();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 3) return int'($urandom_range(DEPTH, 1023));
        if (r < 50) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, DEPTH - 1));
    endfunction

    logic [W-1:0] coll_exp;
    int           cnt;
    int           npulse;
    int           first_s;

    initial begin
        idle();
`ifdef OBJ_STORE_FWD_EN
        coll_exp = W'(8'hBB);
`else
        coll_exp = W'(8'hAA);
`endif
        #3 sys_rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) step();
        sys_rst_n = 1'b1;
        wait_ready(cnt);
        check("ready_latency", cnt, DEPTH + 1);

        load_signal_in = 4'b0001;
        load_object_index_in[0] = 10'd5;
        step(); idle(); step(); step();
        check("slot5_valid", load_valid_out[0], 1);
        check("slot5_data", load_object_data_out[0], 0);

        do_write(3, W'(16'h1234));
        load_signal_in = 4'hF;
        for (int k = 0; k < 4; k++) load_object_index_in[k] = 10'd3;
        step(); idle(); step(); step();
        check("wr_rd_valid", load_valid_out, 4'hF);
        for (int k = 0; k < 4; k++)
            check($sformatf("wr_rd_data%0d", k), load_object_data_out[k], 16'h1234);

        do_write(7, W'(8'hAA));
        save_signal_in = 1'b1;
        save_object_index_in = 10'd7;
        save_object_data_in = W'(8'hBB);
        load_signal_in = 4'b0001;
        load_object_index_in[0] = 10'd7;
        step(); idle(); step(); step();
        check("collision_data", load_object_data_out[0], coll_exp);

        load_signal_in = 4'b0010;
        load_object_index_in[1] = 10'd200;
        save_signal_in = 1'b1;
        save_object_index_in = 10'd300;
        save_object_data_in = W'(8'h55);
        step(); idle(); step(); step();
        check("oor_valid", load_valid_out[1], 1);
        check("oor_data", load_object_data_out[1], 0);
        check("oor_err", range_err_out, 1);
        load_signal_in = 4'b0001;
        load_object_index_in[0] = 10'd44;
        step(); idle(); step(); step();
        check("oor_no_alias", load_object_data_out[0], 0);

        npulse = 0;
        first_s = -1;
        for (int s = 0; s < 10; s++) begin
            if (s < 8) begin
                load_signal_in = 4'hF;
                for (int k = 0; k < 4; k++) load_object_index_in[k] = 10'(s);
            end else begin
                idle();
            end
            step();
            if (load_valid_out[0]) begin
                npulse++;
                if (first_s < 0) first_s = s;
                if (s == 5) check("b2b_slot3", load_object_data_out[0], 16'h1234);
                if (s == 9) check("b2b_slot7", load_object_data_out[0], 8'hBB);
            end
        end
        idle();
        check("b2b_count", npulse, 8);
        check("b2b_first", first_s, 2);

        do_write(9, W'(16'h9999));
        load_signal_in = 4'b0100;
        load_object_index_in[2] = 10'd9;
        step(); idle(); step();
        sys_rst_n = 1'b0;
        npulse = 0;
        repeat (4) begin
            step();
            if (load_valid_out[2]) npulse++;
        end
        check("rst_mid_no_valid", npulse, 0);
        sys_rst_n = 1'b1;
        wait_ready(cnt);
        check("ready_latency2", cnt, DEPTH + 1);
        check("err_cleared", range_err_out, 0);
        load_signal_in = 4'b0100;
        load_object_index_in[2] = 10'd9;
        step(); idle(); step(); step();
        check("rst_mid_valid", load_valid_out[2], 1);
        check("rst_mid_data", load_object_data_out[2], 0);

        for (int c = 0; c < 1500; c++) begin
            load_signal_in = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) load_object_index_in[k] = 10'(pick_idx());
            save_signal_in = 1'($urandom_range(0, 1));
            save_object_index_in = 10'(pick_idx());
            save_object_data_in = W'({$urandom(), $urandom(), $urandom(), $urandom()});
            step();
        end
        idle();
        repeat (4) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
